// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage access sequencer: op codes, FSM states,
// byte-enable patterns and the alignment rule.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_OP_WORD = 2'b00;
    localparam logic [1:0] MEM_OP_HALF = 2'b01;
    localparam logic [1:0] MEM_OP_BYTE = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;
    localparam logic [3:0] BYTEEN_WORD = 4'b1111;
    localparam logic [3:0] BYTEEN_HI   = 4'b1100;
    localparam logic [3:0] BYTEEN_LO   = 4'b0011;
    localparam logic [3:0] BYTEEN_B0   = 4'b0001;

    // The reserved op 2'b11 falls into the word case everywhere.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
        case (op)
            MEM_OP_HALF: return addr_lo[0];
            MEM_OP_BYTE: return 1'b0;
            default:     return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// load_align: selects the addressed half/byte lane of a bus read word and
// sign- or zero-extends it; word loads pass through unchanged.
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  op,
    input  logic        uns,
    output logic [31:0] result
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every branch of a combinational block must assign its outputs;
        // the default up front is what keeps this from inferring a latch.
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
    end

    always_comb begin
        result = rdata;
        case (op)
            MEM_OP_HALF: result = {{16{~uns & half_lane[15]}}, half_lane};
            MEM_OP_BYTE: result = {{24{~uns & byte_lane[7]}}, byte_lane};
            default:     result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer with alignment checks, a
// req/gnt/rvalid bus handshake and a timeout. Optional macro: UNSIGNED_LOAD_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_we,
    input  logic [1:0]  mem_op,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        stall,
    output logic        m_data_req,
    input  logic        m_data_gnt,
    input  logic        m_data_rvalid,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);

    logic [1:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [1:0]           op_q, op_d;
    logic                 uns_q, uns_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 adel_q, adel_d;
    logic                 ades_q, ades_d;
    logic                 berr_q, berr_d;

    logic                 uns_in;
    logic                 misaligned;
    logic                 timeout;
    logic [31:0]          load_data;
    logic [31:0]          lane_wdata;
    logic [3:0]           lane_byteen;

`ifdef UNSIGNED_LOAD_EN
    assign uns_in = mem_unsigned;
`else
    logic unused_mem_unsigned;
    assign unused_mem_unsigned = mem_unsigned;
    assign uns_in = 1'b0;
`endif

    assign misaligned = is_misaligned(mem_op, mem_addr[1:0]);
    assign timeout    = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && (cnt_q == TIMEOUT_CNT);

    load_align u_load_align (
        .rdata   (m_data_rdata),
        .addr_lo (addr_q[1:0]),
        .op      (op_q),
        .uns     (uns_q),
        .result  (load_data)
    );

    always_comb begin
        lane_byteen = BYTEEN_WORD;
        lane_wdata  = wdata_q;
        case (op_q)
            MEM_OP_HALF: begin
                lane_byteen = addr_q[1] ? BYTEEN_HI : BYTEEN_LO;
                lane_wdata  = {2{wdata_q[15:0]}};
            end
            MEM_OP_BYTE: begin
                lane_byteen = BYTEEN_B0 << addr_q[1:0];
                lane_wdata  = {4{wdata_q[7:0]}};
            end
            default: begin
                lane_byteen = BYTEEN_WORD;
                lane_wdata  = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        we_d    = we_q;
        op_d    = op_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        adel_d  = adel_q;
        ades_d  = ades_q;
        berr_d  = berr_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    we_d    = mem_we;
                    op_d    = mem_op;
                    uns_d   = uns_in;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    rdata_d = '0;
                    adel_d  = misaligned & ~mem_we;
                    ades_d  = misaligned & mem_we;
                    berr_d  = 1'b0;
                    state_d = misaligned ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    berr_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (m_data_gnt) begin
                    state_d = we_q ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    berr_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (m_data_rvalid) begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its peers regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= MEM_OP_WORD;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            adel_q  <= adel_d;
            ades_q  <= ades_d;
            berr_q  <= berr_d;
        end
    end

    // Outputs are decoded from state so an async reset clears them at once.
    assign mem_ready     = (state_q == ST_IDLE);
    assign stall         = (state_q != ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = resp_valid ? rdata_q : '0;
    assign exc_adel      = resp_valid & adel_q;
    assign exc_ades      = resp_valid & ades_q;
    assign bus_err       = resp_valid & berr_q;

    assign m_data_req    = (state_q == ST_REQ) && !timeout;
    assign m_data_addr   = m_data_req ? {addr_q[31:2], 2'b00} : '0;
    assign m_data_wdata  = (m_data_req && we_q) ? lane_wdata : '0;
    assign m_data_byteen = (m_data_req && we_q) ? lane_byteen : BYTEEN_NONE;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions compared against a behavioural access model.
module tb_mem_access_ctrl;

    localparam int TO = 255;

    logic        clk;
    logic        reset_n;
    logic        mem_valid, mem_ready, mem_we, mem_unsigned;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        resp_valid, exc_adel, exc_ades, bus_err, stall;
    logic [31:0] resp_rdata;
    logic        m_data_req, m_data_gnt, m_data_rvalid;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;   // REQ cycles before gnt; <0 = never
        int          rv_dly;    // WAIT cycles before rvalid; <0 = never
        logic        stray;     // drive junk rvalid while requesting
    } txn_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        adel, ades, berr;
        int          req_cycles;
        logic [31:0] addr, wdata;
        logic [3:0]  byteen;
        logic        stall_bad, unstable, after_ok, ready_start;
    } obs_t;

    mem_access_ctrl #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_op        (mem_op),
        .mem_unsigned  (mem_unsigned),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .exc_adel      (exc_adel),
        .exc_ades      (exc_ades),
        .bus_err       (bus_err),
        .stall         (stall),
        .m_data_req    (m_data_req),
        .m_data_gnt    (m_data_gnt),
        .m_data_rvalid (m_data_rvalid),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outcome of one access, from access size, address and bus timing.
    function automatic obs_t model(input txn_t t);
        obs_t        e;
        int          size, a;
        logic [31:0] mask, v;
        logic        uns_eff;
`ifdef UNSIGNED_LOAD_EN
        uns_eff = t.uns;
`else
        uns_eff = 1'b0;
`endif
        e = '{default: '0};
        size = (t.op == 2'b01) ? 2 : (t.op == 2'b10) ? 1 : 4;
        a = int'(t.addr[1:0]);
        if (a % size != 0) begin
            e.lat = 1; e.adel = !t.we; e.ades = t.we;
            return e;
        end
        mask     = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
        e.addr   = t.addr & 32'hFFFF_FFFC;
        e.byteen = t.we ? 4'(((1 << size) - 1) << a) : 4'h0;
        e.wdata  = !t.we ? 32'h0 : (size == 4) ? t.wdata :
                   (t.wdata & mask) * ((size == 2) ? 32'h0001_0001 : 32'h0101_0101);
        if (t.gnt_dly < 0 || (!t.we && t.rv_dly < 0)) begin
            e.lat = TO + 2; e.berr = 1'b1;
            e.req_cycles = (t.gnt_dly < 0) ? TO : t.gnt_dly + 1;
            return e;
        end
        e.req_cycles = t.gnt_dly + 1;
        if (t.we) begin
            e.lat = 2 + t.gnt_dly;
            return e;
        end
        e.lat = 3 + t.gnt_dly + t.rv_dly;
        v = (t.rdata >> (8 * a)) & mask;
        if (size < 4 && !uns_eff && v[8 * size - 1]) v = v | ~mask;
        e.rdata = v;
        return e;
    endfunction

    // Issue one access at a negedge and play the bus side until the response.
    task automatic run_txn(input txn_t t, output obs_t o);
        int req_n, wait_n;
        logic granted;
        o = '{default: '0};
        o.lat = -1;
        o.ready_start = mem_ready;
        mem_valid = 1'b1; mem_we = t.we; mem_op = t.op; mem_unsigned = t.uns;
        mem_addr = t.addr; mem_wdata = t.wdata;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
        mem_we = 1'($urandom); mem_op = 2'($urandom);
        req_n = 0; wait_n = 0; granted = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (resp_valid) begin
                o.lat = cyc; o.rdata = resp_rdata;
                o.adel = exc_adel; o.ades = exc_ades; o.berr = bus_err;
                if (!stall) o.stall_bad = 1'b1;
                break;
            end
            if (!stall || mem_ready) o.stall_bad = 1'b1;
            m_data_gnt = 1'b0; m_data_rvalid = 1'b0; m_data_rdata = $urandom;
            if (m_data_req) begin
                if (o.req_cycles == 0) begin
                    o.addr = m_data_addr; o.wdata = m_data_wdata; o.byteen = m_data_byteen;
                end else if (o.addr !== m_data_addr || o.wdata !== m_data_wdata ||
                             o.byteen !== m_data_byteen) begin
                    o.unstable = 1'b1;
                end
                o.req_cycles++;
                if (t.gnt_dly >= 0 && req_n == t.gnt_dly) begin
                    m_data_gnt = 1'b1; granted = 1'b1;
                end else if (t.stray) begin
                    m_data_rvalid = 1'b1;
                end
                req_n++;
            end else if (granted && !t.we) begin
                if (wait_n == t.rv_dly) begin
                    m_data_rvalid = 1'b1; m_data_rdata = t.rdata;
                end
                wait_n++;
            end
            @(negedge clk);
        end
        m_data_gnt = 1'b0; m_data_rvalid = 1'b0;
        if (o.lat != -1) begin
            @(negedge clk);
            o.after_ok = !resp_valid && mem_ready && !stall && !m_data_req;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (m_data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", m_data_req); end
        checks++; if ({resp_rdata, m_data_addr, m_data_wdata} !== 96'h0)
            begin errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", resp_rdata, m_data_addr, m_data_wdata); end
        checks++; if ({exc_adel, exc_ades, bus_err, m_data_byteen} !== 7'h0)
            begin errors++; $display("FAIL reset_flags: adel=%b ades=%b berr=%b be=%b want 0", exc_adel, exc_ades, bus_err, m_data_byteen); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte_load();
        txn_t t; obs_t o;
        t = '{we: 1'b0, op: 2'b10, uns: 1'b0, addr: 32'h1003, wdata: 32'h0,
              rdata: 32'h80FF_0000, gnt_dly: 0, rv_dly: 0, stray: 1'b0};
        run_txn(t, o);
        checks++; if (o.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", o.rdata); end
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", o.lat); end
        checks++; if (o.stall_bad !== 1'b0) begin errors++; $display("FAIL lb_stall: stall dropped during access"); end
        checks++; if (o.byteen !== 4'h0 || o.addr !== 32'h1000)
            begin errors++; $display("FAIL lb_bus: be=%b addr=%h want 0000/00001000", o.byteen, o.addr); end
        checks++; if (o.after_ok !== 1'b1) begin errors++; $display("FAIL lb_pulse: resp not single-cycle / not back to idle"); end
    endtask

    task automatic test_half_store();
        txn_t t; obs_t o;
        t = '{we: 1'b1, op: 2'b01, uns: 1'b0, addr: 32'h2002, wdata: 32'h1234_ABCD,
              rdata: 32'h0, gnt_dly: 0, rv_dly: 0, stray: 1'b0};
        run_txn(t, o);
        checks++; if (o.byteen !== 4'b1100) begin errors++; $display("FAIL sh_byteen: got %b want 1100", o.byteen); end
        checks++; if (o.wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdata); end
        checks++; if (o.addr !== 32'h2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", o.addr); end
        checks++; if (o.lat !== 2) begin errors++; $display("FAIL sh_latency: got %0d want 2", o.lat); end
        checks++; if ({o.adel, o.ades, o.berr} !== 3'b000 || o.rdata !== 32'h0)
            begin errors++; $display("FAIL sh_resp: flags=%b rdata=%h want 000/0", {o.adel, o.ades, o.berr}, o.rdata); end
    endtask

    task automatic test_misaligned();
        txn_t t; obs_t o;
        t = '{we: 1'b0, op: 2'b00, uns: 1'b0, addr: 32'h3001, wdata: 32'h0,
              rdata: 32'hDEAD_BEEF, gnt_dly: 0, rv_dly: 0, stray: 1'b0};
        run_txn(t, o);
        checks++; if (o.req_cycles !== 0) begin errors++; $display("FAIL adel_noreq: req cycles %0d want 0", o.req_cycles); end
        checks++; if ({o.adel, o.ades, o.berr} !== 3'b100) begin errors++; $display("FAIL adel_flags: got %b want 100", {o.adel, o.ades, o.berr}); end
        checks++; if (o.rdata !== 32'h0 || o.lat !== 1) begin errors++; $display("FAIL adel_resp: rdata=%h lat=%0d want 0/1", o.rdata, o.lat); end
        t.we = 1'b1; t.op = 2'b01; t.addr = 32'h2001;
        run_txn(t, o);
        checks++; if (o.req_cycles !== 0 || {o.adel, o.ades, o.berr} !== 3'b010)
            begin errors++; $display("FAIL ades: req=%0d flags=%b want 0/010", o.req_cycles, {o.adel, o.ades, o.berr}); end
    endtask

    task automatic test_timeout();
        txn_t t; obs_t o;
        t = '{we: 1'b1, op: 2'b00, uns: 1'b0, addr: 32'h4000, wdata: 32'h5555_AAAA,
              rdata: 32'h0, gnt_dly: -1, rv_dly: 0, stray: 1'b0};
        run_txn(t, o);
        checks++; if (o.berr !== 1'b1 || o.lat !== TO + 2)
            begin errors++; $display("FAIL to_gnt: berr=%b lat=%0d want 1/%0d", o.berr, o.lat, TO + 2); end
        checks++; if (o.req_cycles !== TO) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", o.req_cycles, TO); end
        checks++; if (o.after_ok !== 1'b1) begin errors++; $display("FAIL to_after: req/resp not low after abort"); end
        t.we = 1'b0; t.gnt_dly = 0; t.rv_dly = -1;
        run_txn(t, o);
        checks++; if (o.berr !== 1'b1 || o.rdata !== 32'h0 || o.lat !== TO + 2)
            begin errors++; $display("FAIL to_rvalid: berr=%b rdata=%h lat=%0d", o.berr, o.rdata, o.lat); end
        for (int i = 0; i < 3; i++) begin
            m_data_rvalid = 1'b1; m_data_rdata = $urandom;
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0 || mem_ready !== 1'b1)
                begin errors++; $display("FAIL stray_rvalid: resp_valid=%b ready=%b want 0/1", resp_valid, mem_ready); end
        end
        m_data_rvalid = 1'b0;
        t = '{we: 1'b0, op: 2'b00, uns: 1'b0, addr: 32'h4004, wdata: 32'h0,
              rdata: 32'h1357_9BDF, gnt_dly: 1, rv_dly: 1, stray: 1'b0};
        run_txn(t, o);
        checks++; if (o.rdata !== 32'h1357_9BDF || o.lat !== 5 || o.berr !== 1'b0)
            begin errors++; $display("FAIL to_recover: rdata=%h lat=%0d berr=%b", o.rdata, o.lat, o.berr); end
    endtask

    task automatic test_reset_mid();
        txn_t t; obs_t o, e;
        mem_valid = 1'b1; mem_we = 1'b1; mem_op = 2'b00; mem_addr = 32'h50; mem_wdata = 32'h1;
        @(posedge clk); @(negedge clk);
        mem_valid = 1'b0;
        checks++; if (m_data_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: req=%b want 1", m_data_req); end
        reset_n = 1'b0; #1;
        checks++; if (m_data_req !== 1'b0 || mem_ready !== 1'b1)
            begin errors++; $display("FAIL rst_in_req: req=%b ready=%b want 0/1", m_data_req, mem_ready); end
        @(negedge clk); reset_n = 1'b1; @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; mem_op = 2'b00; mem_addr = 32'h60;
        @(posedge clk); @(negedge clk);
        mem_valid = 1'b0; m_data_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        m_data_gnt = 1'b0;
        reset_n = 1'b0; #1;
        checks++; if ({m_data_req, stall, resp_valid, mem_ready} !== 4'b0001)
            begin errors++; $display("FAIL rst_in_wait: req/stall/resp/ready=%b want 0001", {m_data_req, stall, resp_valid, mem_ready}); end
        m_data_rvalid = 1'b1; m_data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resp: resp_valid=%b want 0", resp_valid); end
        m_data_rvalid = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        t = '{we: 1'b0, op: 2'b10, uns: 1'b0, addr: 32'h71, wdata: 32'h0,
              rdata: 32'h0000_7F00, gnt_dly: 0, rv_dly: 2, stray: 1'b0};
        e = model(t);
        run_txn(t, o);
        checks++; if (o.rdata !== e.rdata || o.lat !== e.lat)
            begin errors++; $display("FAIL rst_after: rdata=%h lat=%0d want %h/%0d", o.rdata, o.lat, e.rdata, e.lat); end
    endtask

    task automatic test_unsigned();
        txn_t t; obs_t o;
        logic [31:0] want;
`ifdef UNSIGNED_LOAD_EN
        want = 32'h0000_8001;
`else
        want = 32'hFFFF_8001;
`endif
        t = '{we: 1'b0, op: 2'b01, uns: 1'b1, addr: 32'h0, wdata: 32'h0,
              rdata: 32'h0000_8001, gnt_dly: 0, rv_dly: 0, stray: 1'b0};
        run_txn(t, o);
        checks++; if (o.rdata !== want) begin errors++; $display("FAIL lhu: got %h want %h", o.rdata, want); end
        t.uns = 1'b0;
        run_txn(t, o);
        checks++; if (o.rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got %h want ffff8001", o.rdata); end
    endtask

    // Back-to-back random accesses: each new access starts in the first idle cycle.
    task automatic test_random();
        txn_t t; obs_t o, e;
        for (int n = 0; n < 60; n++) begin
            t.we = 1'($urandom); t.op = 2'($urandom); t.uns = 1'($urandom);
            t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
            t.gnt_dly = int'($urandom_range(0, 3)); t.rv_dly = int'($urandom_range(0, 3));
            t.stray = 1'($urandom);
            e = model(t);
            run_txn(t, o);
            checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rnd%0d_lat: got %0d want %0d", n, o.lat, e.lat); end
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", n, o.rdata, e.rdata); end
            checks++; if ({o.adel, o.ades, o.berr} !== {e.adel, e.ades, e.berr})
                begin errors++; $display("FAIL rnd%0d_flags: got %b want %b", n, {o.adel, o.ades, o.berr}, {e.adel, e.ades, e.berr}); end
            checks++; if (o.req_cycles !== e.req_cycles) begin errors++; $display("FAIL rnd%0d_req: got %0d want %0d", n, o.req_cycles, e.req_cycles); end
            if (e.req_cycles > 0) begin
                checks++; if (o.addr !== e.addr || o.wdata !== e.wdata || o.byteen !== e.byteen)
                    begin errors++; $display("FAIL rnd%0d_bus: addr=%h wdata=%h be=%b want %h/%h/%b", n, o.addr, o.wdata, o.byteen, e.addr, e.wdata, e.byteen); end
            end
            checks++; if ({o.ready_start, o.stall_bad, o.unstable, o.after_ok} !== 4'b1001)
                begin errors++; $display("FAIL rnd%0d_hs: ready/stall_bad/unstable/after=%b want 1001", n, {o.ready_start, o.stall_bad, o.unstable, o.after_ok}); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mem_valid = 1'b0; mem_we = 1'b0; mem_op = 2'b00; mem_unsigned = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        m_data_gnt = 1'b0; m_data_rvalid = 1'b0; m_data_rdata = '0;
        test_reset();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_unsigned();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
